// File: rtl/fifo_rd_sched_pkg.sv
// fifo_rd_sched_pkg: shared FSM encoding and default sizing for the FIFO read scheduler
// Contents: state_t (IDLE/BURST), default WordWidth/NumSrc/BurstMax constants.
package fifo_rd_sched_pkg;
   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
   localparam int DEF_WORD_WIDTH = 64;
   localparam int DEF_NUM_SRC    = 4;
   localparam int DEF_BURST_MAX  = 8;
endpackage

// File: rtl/fifo_rd_sched_rr_pick.sv
// fifo_rd_sched_rr_pick: round-robin picker, first requester after last with wrap-around
// Ports:
//   req  - per-source request vector
//   last - index granted most recently; search starts at last+1
//   pick - chosen index (only meaningful when any=1)
//   any  - at least one request bit is set
module fifo_rd_sched_rr_pick
   import fifo_rd_sched_pkg::*;
#(
   parameter int NumSrc = DEF_NUM_SRC,
   localparam int IdxW = $clog2(NumSrc)
) (
   input  logic [NumSrc-1:0] req,
   input  logic [IdxW-1:0]   last,
   output logic [IdxW-1:0]   pick,
   output logic              any
);
   logic [IdxW-1:0] idx;
   assign any = |req;
   // Scan from the farthest candidate back to last+1 so the nearest requester wins.
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int k = NumSrc; k > 0; k--) begin
         idx = IdxW'((int'(last) + k) % NumSrc);
         if (req[idx]) pick = idx;
      end
   end
endmodule

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: round-robin burst reader draining several FWFT FIFOs into one registered stream
// Ports:
//   sched_clk, sched_reset_n - clock, asynchronous active-low reset
//   sched_en                 - allows new grants (a running burst always completes)
//   src_empty, src_r_data    - per-FIFO empty flags and fall-through data (source i at [i*WordWidth +: WordWidth])
//   src_rd                   - combinational one-hot pop strobe to the granted FIFO
//   out_valid, out_ready     - output handshake
//   out_data, out_src, out_first - registered word, its source index, first-word-of-grant marker
module fifo_rd_sched
   import fifo_rd_sched_pkg::*;
#(
   parameter int WordWidth = DEF_WORD_WIDTH,
   parameter int NumSrc    = DEF_NUM_SRC,
   parameter int BurstMax  = DEF_BURST_MAX,
   localparam int IdxW = $clog2(NumSrc),
   localparam int CntW = $clog2(BurstMax) + 1
) (
   input  logic                        sched_clk,
   input  logic                        sched_reset_n,
   input  logic                        sched_en,
   input  logic [NumSrc-1:0]           src_empty,
   input  logic [NumSrc*WordWidth-1:0] src_r_data,
   output logic [NumSrc-1:0]           src_rd,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WordWidth-1:0]        out_data,
   output logic [IdxW-1:0]             out_src,
   output logic                        out_first
);
   state_t                state, state_nxt;
   logic [IdxW-1:0]       grant, pick;
   logic [CntW-1:0]       count;
   logic                  any_req, take, can_load, pop, exit_burst;
   logic [WordWidth-1:0]  words [NumSrc];

   for (genvar i = 0; i < NumSrc; i++) begin : g_words
      assign words[i] = src_r_data[i*WordWidth +: WordWidth];
   end

   fifo_rd_sched_rr_pick #(.NumSrc(NumSrc)) rr_pick (
      .req  (~src_empty),
      .last (grant),
      .pick (pick),
      .any  (any_req)
   );

   // grant doubles as last_grant: it keeps its value after the burst ends and seeds the next search.
   assign take       = (state == IDLE) & sched_en & any_req;
   assign can_load   = ~out_valid | out_ready;
   assign pop        = (state == BURST) & ~src_empty[grant] & can_load;
   assign exit_burst = (pop & (count == CntW'(BurstMax - 1))) | ((state == BURST) & src_empty[grant] & can_load);
   assign src_rd     = pop ? NumSrc'(1) << grant : '0;

   always_ff @(posedge sched_clk or negedge sched_reset_n) begin
      if (!sched_reset_n) state <= IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (take ? BURST : IDLE) : (exit_burst ? IDLE : BURST);
   end

   always_ff @(posedge sched_clk or negedge sched_reset_n) begin
      if (!sched_reset_n) begin
         grant     <= IdxW'(NumSrc - 1);
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_first <= 1'b0;
      end else begin
         if (take) begin
            grant <= pick;
            count <= '0;
         end
         if (pop) begin
            out_data  <= words[grant];
            out_src   <= grant;
            out_first <= count == '0;
            out_valid <= 1'b1;
            count     <= count + CntW'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched: scoreboard bench for fifo_rd_sched with FIFO models on every source
module tb_fifo_rd_sched;
   localparam int WW = 64, NS = 4, DEPTH = 256;

   logic sched_clk = 1'b0, sched_reset_n = 1'b0, sched_en = 1'b0, out_ready = 1'b0;
   logic [NS-1:0] src_empty, src_rd;
   logic [NS*WW-1:0] src_r_data;
   logic out_valid, out_first;
   logic [WW-1:0] out_data;
   logic [1:0] out_src;

   logic [WW-1:0] mem [NS][DEPTH];
   int wr_ptr [NS] = '{default: 0};
   int rd_ptr [NS] = '{default: 0};
   int total = 0, bad = 0, cyc = 0, acc = 0, prev_cyc = 0;

   typedef struct {logic [1:0] src; logic [WW-1:0] data; logic first; int gap;} exp_t;
   exp_t exp_q[$];
   exp_t e;

   fifo_rd_sched dut (
      .sched_clk     (sched_clk),
      .sched_reset_n (sched_reset_n),
      .sched_en      (sched_en),
      .src_empty     (src_empty),
      .src_r_data    (src_r_data),
      .src_rd        (src_rd),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_src       (out_src),
      .out_first     (out_first)
   );

   always #5 sched_clk = ~sched_clk;

   for (genvar i = 0; i < NS; i++) begin : g_fifo
      assign src_empty[i] = rd_ptr[i] == wr_ptr[i];
      assign src_r_data[i*WW +: WW] = mem[i][rd_ptr[i] % DEPTH];
   end

   always @(posedge sched_clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NS; i++) if (src_rd[i]) rd_ptr[i] <= rd_ptr[i] + 1;
   end

   function automatic logic [WW-1:0] word(int s, int n);
      return 64'hA000_0000_0000_0000 | (64'(s) << 32) | 64'(n);
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   always @(negedge sched_clk) begin
      if (sched_reset_n && out_valid && out_ready) begin
         acc++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got src %0d data %0h, want none", out_src, out_data);
         end else begin
            e = exp_q.pop_front();
            chk("out_src", 64'(out_src), 64'(e.src));
            chk("out_data", out_data, e.data);
            chk("out_first", 64'(out_first), 64'(e.first));
            if (e.gap != 0) chk("spacing", 64'(cyc - prev_cyc), 64'(e.gap));
         end
         prev_cyc = cyc;
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge sched_clk);
      #2;
   endtask

   task automatic load(int s, int n);
      for (int k = 0; k < n; k++) begin
         mem[s][wr_ptr[s] % DEPTH] = word(s, wr_ptr[s]);
         wr_ptr[s]++;
      end
   endtask

   task automatic push(int s, int idx, bit first, int gap);
      exp_q.push_back('{src: 2'(s), data: word(s, idx), first: first, gap: gap});
   endtask

   task automatic drain(string nm, int lim);
      int c = 0;
      while (exp_q.size() != 0 && c < lim) begin
         @(posedge sched_clk);
         c++;
      end
      #2;
      chk(nm, 64'(exp_q.size()), 64'(0));
      step(3);
   endtask

   task automatic wait_acc(string nm, int n);
      int c = 0;
      int t;
      t = acc + n;
      while (acc < t && c < 60) begin
         @(posedge sched_clk);
         c++;
      end
      chk(nm, 64'(acc >= t), 64'(1));
      #2;
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_data"}, out_data, 64'(0));
      chk({tag, "_src"}, 64'(out_src), 64'(0));
      chk({tag, "_first"}, 64'(out_first), 64'(0));
      chk({tag, "_rd"}, 64'(src_rd), 64'(0));
   endtask

   initial begin
      int b0, b1, b2, gp;
      int b [NS];
      // reset state with enable already high
      sched_en = 1'b1;
      step(2);
      chk_zero("reset");
      sched_reset_n = 1'b1;
      out_ready = 1'b1;
      step(2);
      // source 2 alone, 3 words; grant one cycle after data appears, pop the next
      b2 = wr_ptr[2];
      load(2, 3);
      push(2, b2, 1, 0);
      push(2, b2 + 1, 0, 1);
      push(2, b2 + 2, 0, 1);
      step(1);
      chk("lat_rd", 64'(src_rd), 64'(4'b0100));
      chk("lat_valid", 64'(out_valid), 64'(0));
      drain("s1_drain", 50);
      chk("s1_idle_valid", 64'(out_valid), 64'(0));
      chk("s1_idle_rd", 64'(src_rd), 64'(0));
      // source 1 runs dry after 2 words, search continues at source 2
      b1 = wr_ptr[1];
      b2 = wr_ptr[2];
      load(1, 2);
      load(2, 3);
      push(1, b1, 1, 0);
      push(1, b1 + 1, 0, 1);
      push(2, b2, 1, 3);
      push(2, b2 + 1, 0, 1);
      push(2, b2 + 2, 0, 1);
      drain("s3_drain", 50);
      // fresh reset so the rotation restarts at source 0
      sched_reset_n = 1'b0;
      step(2);
      sched_reset_n = 1'b1;
      step(1);
      // all four sources, 20 words each: 8,8,4 per source in rotation
      for (int s = 0; s < NS; s++) begin
         b[s] = wr_ptr[s];
         load(s, 20);
      end
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < NS; s++)
            for (int k = 0; k < (r < 2 ? 8 : 4); k++) begin
               gp = (r == 0 && s == 0 && k == 0) ? 0 : (k > 0) ? 1 : (r == 2 && s > 0) ? 3 : 2;
               push(s, b[s] + r * 8 + k, k == 0, gp);
            end
      drain("s2_drain", 400);
      // downstream stall mid-burst holds the output and stops popping
      b0 = wr_ptr[0];
      load(0, 8);
      for (int k = 0; k < 8; k++) push(0, b0 + k, k == 0, 0);
      wait_acc("s4_progress", 3);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step(1);
         chk("stall_rd", 64'(src_rd), 64'(0));
         chk("stall_valid", 64'(out_valid), 64'(1));
         chk("stall_data", out_data, word(0, b0 + 3));
         chk("stall_src", 64'(out_src), 64'(0));
         chk("stall_first", 64'(out_first), 64'(0));
      end
      out_ready = 1'b1;
      drain("s4_drain", 50);
      // enable drops mid-burst: burst still reaches 8 words, then no new grant
      b1 = wr_ptr[1];
      b2 = wr_ptr[2];
      load(1, 10);
      load(2, 2);
      for (int k = 0; k < 8; k++) push(1, b1 + k, k == 0, 0);
      push(2, b2, 1, 0);
      push(2, b2 + 1, 0, 0);
      push(1, b1 + 8, 1, 0);
      push(1, b1 + 9, 0, 0);
      wait_acc("s5_progress", 2);
      sched_en = 1'b0;
      step(20);
      chk("s5_left", 64'(exp_q.size()), 64'(4));
      chk("s5_hold_valid", 64'(out_valid), 64'(0));
      chk("s5_hold_rd", 64'(src_rd), 64'(0));
      sched_en = 1'b1;
      drain("s5_drain", 60);
      // reset mid-burst on source 2; afterwards source 0 goes first
      b2 = wr_ptr[2];
      b0 = wr_ptr[0];
      load(2, 6);
      load(0, 2);
      for (int k = 0; k < 6; k++) push(2, b2 + k, k == 0, 0);
      wait_acc("s6_progress", 2);
      sched_reset_n = 1'b0;
      #1;
      chk_zero("midrst");
      exp_q.delete();
      chk("s6_popped", 64'(rd_ptr[2] - b2), 64'(3));
      step(2);
      chk_zero("midrst_hold");
      push(0, b0, 1, 0);
      push(0, b0 + 1, 0, 1);
      push(2, b2 + 3, 1, 3);
      push(2, b2 + 4, 0, 1);
      push(2, b2 + 5, 0, 1);
      sched_reset_n = 1'b1;
      drain("s6_drain", 50);
      chk("end_valid", 64'(out_valid), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
